// File: rtl/target_ctrl.sv
// Reaction-game controller: requests a random target, shows it for a fixed time,
// scores the player's press against it, and repeats for a fixed number of rounds.
module target_ctrl #(
    parameter int N_TARGETS  = 8,
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 500,
    parameter int GAP_TICKS  = 200,
    parameter int ROUNDS     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic [6:0] hit_idx,
    input  logic [6:0] rnd_in,
    output logic       rnd_trig,
    output logic [6:0] rnd_max,
    output logic [6:0] target,
    output logic       target_valid,
    output logic [7:0] score,
    output logic [4:0] round,
    output logic       hit_ok,
    output logic       miss,
    output logic       busy,
    output logic       done
);

    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXTICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int TW       = $clog2(MAXTICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [6:0]    TGT_COUNT  = 7'(N_TARGETS);
    localparam logic [6:0]    TGT_LAST   = 7'(N_TARGETS - 1);
    localparam logic [4:0]    ROUND_LAST = 5'(ROUNDS);

    typedef enum logic [2:0] {IDLE, REQ, CAPT, SHOW, GAP, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [TW-1:0] ticks;

    logic [PW-1:0] presc_nxt;
    logic [TW-1:0] ticks_nxt;
    logic          tick_end;
    logic          show_end;
    logic          gap_end;
    logic [6:0]    v;
    logic [6:0]    new_target;

    assign rnd_max = TGT_LAST;

    // target doubles as the previous-target register: it holds outside SHOW
    // and is cleared by reset, so a repeat draw can be nudged to the next index.
    always_comb begin
        tick_end   = (presc == PRESC_LAST);
        show_end   = tick_end && (ticks == HOLD_LAST);
        gap_end    = tick_end && (ticks == GAP_LAST);
        presc_nxt  = tick_end ? '0 : presc + PW'(1);
        ticks_nxt  = tick_end ? ticks + TW'(1) : ticks;
        v          = (rnd_in >= TGT_COUNT) ? 7'd0 : rnd_in;
        new_target = v;
        if ((v == target) && (round != 5'd0))
            new_target = (v == TGT_LAST) ? 7'd0 : v + 7'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            presc        <= '0;
            ticks        <= '0;
            target       <= '0;
            target_valid <= 1'b0;
            score        <= '0;
            round        <= '0;
            rnd_trig     <= 1'b0;
            hit_ok       <= 1'b0;
            miss         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rnd_trig <= 1'b0;
            hit_ok   <= 1'b0;
            miss     <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score    <= '0;
                        round    <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        rnd_trig <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: state <= CAPT;
                CAPT: begin
                    target       <= new_target;
                    target_valid <= 1'b1;
                    presc        <= '0;
                    ticks        <= '0;
                    state        <= SHOW;
                end
                SHOW: begin
                    // A press beats a coincident timeout; either way exactly one pulse.
                    if (hit || show_end) begin
                        if (hit && (hit_idx == target)) begin
                            hit_ok <= 1'b1;
                            if (score != 8'hFF)
                                score <= score + 8'd1;
                        end else begin
                            miss <= 1'b1;
                        end
                        target_valid <= 1'b0;
                        round        <= round + 5'd1;
                        presc        <= '0;
                        ticks        <= '0;
                        state        <= GAP;
                    end else begin
                        presc <= presc_nxt;
                        ticks <= ticks_nxt;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (round == ROUND_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rnd_trig <= 1'b1;
                            state    <= REQ;
                        end
                    end else begin
                        presc <= presc_nxt;
                        ticks <= ticks_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_ctrl.sv
// Randomized bench for target_ctrl: each round's target, outcome and timing are
// predicted from the game rules and compared against the DUT.
module tb_target_ctrl;

    localparam int N      = 8;
    localparam int TD     = 4;
    localparam int HOLD   = 3;
    localparam int GAPT   = 2;
    localparam int ROUNDS = 2;
    localparam int SHOW_CYC = HOLD * TD;
    localparam int GAP_CYC  = GAPT * TD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic [6:0] hit_idx = '0;
    logic [6:0] rnd_in = '0;
    logic       rnd_trig;
    logic [6:0] rnd_max;
    logic [6:0] target;
    logic       target_valid;
    logic [7:0] score;
    logic [4:0] round;
    logic       hit_ok;
    logic       miss;
    logic       busy;
    logic       done;

    int compared = 0;
    int mismatched = 0;
    int exp_prev = 0;
    int exp_score = 0;
    int exp_round = 0;

    target_ctrl #(
        .N_TARGETS(N), .TICK_DIV(TD), .HOLD_TICKS(HOLD), .GAP_TICKS(GAPT), .ROUNDS(ROUNDS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .hit_idx(hit_idx),
        .rnd_in(rnd_in), .rnd_trig(rnd_trig), .rnd_max(rnd_max), .target(target),
        .target_valid(target_valid), .score(score), .round(round), .hit_ok(hit_ok),
        .miss(miss), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_target"}, target, 0);
        checkOutput({tag, "_tv"}, target_valid, 0);
        checkOutput({tag, "_score"}, score, 0);
        checkOutput({tag, "_round"}, round, 0);
        checkOutput({tag, "_hit_ok"}, hit_ok, 0);
        checkOutput({tag, "_miss"}, miss, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rnd_trig"}, rnd_trig, 0);
    endtask

    // Called at the negedge before the edge that enters REQ. k = SHOW edge at
    // which the player presses (k > SHOW_CYC means no press at all).
    task automatic applyStimulus(input int rv, input int k, input bit correct,
                                 input bit poke, input bit first, input bit last);
        int exp_t;
        int w;
        bit good;
        rnd_in = 7'(rv);
        if (first) begin
            start = 1'b1;
            exp_score = 0;
            exp_round = 0;
        end
        exp_t = (rv >= N) ? 0 : rv;
        if (exp_round > 0 && exp_t == exp_prev) exp_t = (exp_t + 1) % N;
        exp_prev = exp_t;
        good = (k <= SHOW_CYC) && correct;

        step(); start = 1'b0;
        checkOutput("req_rnd_trig", rnd_trig, 1);
        checkOutput("req_busy", busy, 1);
        checkOutput("req_done", done, 0);
        checkOutput("req_tv", target_valid, 0);
        checkOutput("req_score", score, exp_score);
        checkOutput("req_round", round, exp_round);
        step();
        checkOutput("capt_rnd_trig", rnd_trig, 0);
        checkOutput("capt_tv", target_valid, 0);
        step();
        checkOutput("show_tv", target_valid, 1);
        checkOutput("show_target", target, exp_t);

        for (int j = 1; j <= SHOW_CYC; j++) begin
            if (j == k) begin
                hit = 1'b1;
                if (correct) w = exp_t;
                else begin
                    do w = $urandom_range(0, 127); while (w == exp_t);
                end
                hit_idx = 7'(w);
            end
            if (poke && j == 2) start = 1'b1;
            step(); hit = 1'b0; start = 1'b0;
            if (j < k && j < SHOW_CYC) begin
                checkOutput("show_no_pulse_ok", hit_ok, 0);
                checkOutput("show_no_pulse_miss", miss, 0);
                checkOutput("show_tv_held", target_valid, 1);
            end else begin
                exp_round++;
                if (good && exp_score < 255) exp_score++;
                checkOutput("pulse_hit_ok", hit_ok, good ? 1 : 0);
                checkOutput("pulse_miss", miss, good ? 0 : 1);
                checkOutput("pulse_tv", target_valid, 0);
                checkOutput("pulse_round", round, exp_round);
                checkOutput("pulse_score", score, exp_score);
                checkOutput("pulse_target_hold", target, exp_t);
                break;
            end
        end

        // A press during GAP must have no effect.
        for (int g = 1; g < GAP_CYC; g++) begin
            if (g == 3) begin
                hit = 1'b1;
                hit_idx = 7'(exp_t);
            end
            step(); hit = 1'b0;
            checkOutput("gap_hit_ok", hit_ok, 0);
            checkOutput("gap_miss", miss, 0);
            checkOutput("gap_rnd_trig", rnd_trig, 0);
            checkOutput("gap_busy", busy, 1);
            checkOutput("gap_score", score, exp_score);
        end

        if (last) begin
            step();
            checkOutput("done_done", done, 1);
            checkOutput("done_busy", busy, 0);
            checkOutput("done_rnd_trig", rnd_trig, 0);
            checkOutput("done_round", round, exp_round);
            checkOutput("done_score", score, exp_score);
            step(); step();
            checkOutput("done_held", done, 1);
            checkOutput("done_target_hold", target, exp_t);
        end
    endtask

    task automatic resetMidShow();
        rnd_in = 7'd3;
        start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        checkOutput("rst_pre_tv", target_valid, 1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("rst_async");
        hit = 1'b1;
        hit_idx = 7'd3;
        step(); hit = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("rst_idle_pulse_ok", hit_ok, 0);
            checkOutput("rst_idle_pulse_miss", miss, 0);
            checkOutput("rst_idle_busy", busy, 0);
            checkOutput("rst_idle_tv", target_valid, 0);
            checkOutput("rst_idle_rnd_trig", rnd_trig, 0);
        end
        exp_prev = 0;
    endtask

    function automatic int pickRnd();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3) return exp_prev;
        else if (sel < 5) return $urandom_range(N, 127);
        else return $urandom_range(0, N - 1);
    endfunction

    initial begin
        #2 checkAllZero("reset");
        checkOutput("rnd_max", rnd_max, N - 1);
        step(); step();
        rst_n = 1'b1;
        step(); step();
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_rnd_trig", rnd_trig, 0);

        applyStimulus(5, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(5, SHOW_CYC, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(7, SHOW_CYC + 1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(7, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(100, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, SHOW_CYC + 1, 1'b0, 1'b0, 1'b0, 1'b1);

        resetMidShow();

        for (int g = 0; g < 16; g++) begin
            for (int r = 0; r < ROUNDS; r++) begin
                applyStimulus(pickRnd(), $urandom_range(1, SHOW_CYC + 1),
                              $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                              r == 0, r == ROUNDS - 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/target_ctrl.md
TARGET_CTRL -- requirements
Module: target_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_TARGETS, 8, number of selectable targets (2..64)
- TICK_DIV, 50000, clk cycles per time tick (1 ms at 50 MHz)
- HOLD_TICKS, 500, ticks a target stays shown
- GAP_TICKS, 200, ticks between targets
- ROUNDS, 16, targets per game (1..31)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, 50 MHz system clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle game start pulse
- hit, in, 1, one-cycle player press pulse
- hit_idx, in, 7, index of the pressed target, valid with hit
- rnd_in, in, 7, sampled value from the random-number stage
- rnd_trig, out, 1, sample request to the random-number stage
- rnd_max, out, 7, upper bound for the random-number stage
- target, out, 7, current target index
- target_valid, out, 1, target is shown
- score, out, 8, number of correct hits
- round, out, 5, number of completed rounds
- hit_ok, out, 1, one-cycle correct-hit pulse
- miss, out, 1, one-cycle wrong-hit or timeout pulse
- busy, out, 1, game in progress
- done, out, 1, game finished, held
REQ-003 There SHALL be one clock, clk. Reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 rnd_max SHALL equal N_TARGETS-1, constant.
REQ-005 The FSM SHALL have six states: IDLE, REQ, CAPT, SHOW, GAP, DONE.
REQ-006 In IDLE or DONE, start SHALL clear score and round, deassert done, and enter REQ on the next edge. start SHALL be ignored in all other states.
REQ-007 REQ SHALL last exactly one cycle with rnd_trig=1. rnd_trig SHALL be 0 in all other states.
REQ-008 In CAPT, the value v = (rnd_in >= N_TARGETS) ? 0 : rnd_in SHALL be used.
REQ-009 In CAPT, if v equals the previous target and round>0, target SHALL be set to v+1, wrapping N_TARGETS-1 to 0. Otherwise target SHALL be set to v.
REQ-010 target_valid SHALL assert on the cycle the FSM enters SHOW, which is 3 cycles after the start pulse edge.
REQ-011 A tick prescaler (0..TICK_DIV-1) and a tick counter SHALL both restart on entry to SHOW and on entry to GAP. SHOW timeout SHALL therefore occur exactly HOLD_TICKS*TICK_DIV cycles after entry.
REQ-012 In SHOW:
- hit with hit_idx==target: score+1 (saturating at 255) and a hit_ok pulse.
- hit with any other index: a miss pulse.
- timeout with no hit: a miss pulse.
- Each of these SHALL enter GAP.
REQ-013 If hit and timeout occur in the same cycle, the hit SHALL take precedence; only one pulse SHALL be issued.
REQ-014 hit SHALL be ignored outside SHOW.
REQ-015 hit_ok and miss SHALL be registered and high for exactly one cycle, in the cycle after the triggering edge.
REQ-016 On entry to GAP, target_valid SHALL be 0 and round SHALL increment. GAP SHALL last GAP_TICKS*TICK_DIV cycles.
REQ-017 At the end of GAP, the FSM SHALL enter DONE if round==ROUNDS, else REQ.
REQ-018 target SHALL hold its last value while not in SHOW.
REQ-019 busy SHALL be 1 in states REQ through GAP.
REQ-020 done SHALL be 1 only in DONE.

Reset
REQ-021 rst_n=0 SHALL immediately force, regardless of clk:
- state IDLE
- target=0, score=0, round=0, and the previous-target register cleared
- all single-bit outputs 0
REQ-022 Reset asserted mid-game SHALL abandon the game with no pulse issued. After release, only a new start SHALL begin a game.

Verification
REQ-023 Directed scenarios SHALL use N_TARGETS=8, TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, ROUNDS=2:
- start, rnd_in=5 -> rnd_trig pulse 1 cycle after start; target=5 and target_valid=1 3 cycles after start.
- Target 5 shown, hit with hit_idx=5 -> hit_ok pulse, score=1, round=1, target_valid=0 for 8 cycles.
- Round 2 with rnd_in=5 again -> target=6. With previous target 7 and rnd_in=7 -> target=0. rnd_in=100 -> target=0.
- No hit -> miss exactly 12 cycles after SHOW entry. hit and timeout in the same cycle -> hit_ok only.
- After 2 rounds -> done=1 and busy=0. start during SHOW -> ignored. start in DONE -> score=0, round=0, new game begins.
- rst_n low mid-SHOW -> outputs zero immediately; no hit_ok or miss pulse; state IDLE after release.
